// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_ctrl_pkg
// Description : Shared types and filter-mode codes for the filter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package filter_ctrl_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } pitch_state_t;

    localparam int         FILT_W      = 3;
    localparam logic [2:0] FILT_NONE   = 3'd0;
    localparam logic [2:0] FILT_BRIGHT = 3'd1;
    localparam logic [2:0] FILT_SIREN  = 3'd2;

    function automatic logic [FILT_W-1:0] next_filter(input logic [FILT_W-1:0] cur,
                                                      input int num);
        if (int'(cur) >= num - 1) begin
            return '0;
        end
        return cur + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-FF synchronizer, stable-count debouncer and rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = (r_sync2 != r_level);
    assign w_expire = w_differ && (r_cnt == c_LAST_CNT);
    // Pulse in the cycle the level is about to flip to 1.
    assign o_rise   = w_expire && r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : filter_ctrl
// Description : Frame-synchronous commit of filter mode and averaged pitch.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int NUM_FILTERS     = 3,
    parameter int AVG_LOG2        = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PITCH_W         = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_next,
    input  logic               pitch_valid,
    input  logic [PITCH_W-1:0] pitch_data,
    output logic               pitch_ready,
    input  logic               frame_start,
    output logic [2:0]         filter_number,
    output logic [PITCH_W-1:0] audio_pitch,
    output logic               update
);

    localparam int ACC_W = PITCH_W + AVG_LOG2;

    pitch_state_t       r_state;
    pitch_state_t       w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [PITCH_W-1:0] r_pending_pitch;
    logic [2:0]         r_pending_filter;
    logic [2:0]         r_filter;
    logic [PITCH_W-1:0] r_pitch;
    logic               r_ready;
    logic               r_update;
    logic               w_rise;
    logic               w_hs;
    logic               w_last;
    logic               w_commit_pitch;
    logic [ACC_W-1:0]   w_sum;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (btn_next),
        .o_rise  (w_rise)
    );

    assign w_hs           = pitch_valid && r_ready;
    assign w_last         = w_hs && (r_cnt == {AVG_LOG2{1'b1}});
    assign w_sum          = r_acc + ACC_W'(pitch_data);
    assign w_commit_pitch = (r_state == DONE) && frame_start;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACCUM:   if (w_last) w_next_state = DONE;
            DONE:    if (frame_start) w_next_state = ACCUM;
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready is registered so it stays low throughout reset and rises one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready         <= 1'b0;
            r_acc           <= '0;
            r_cnt           <= '0;
            r_pending_pitch <= '0;
        end else begin
            r_ready <= (w_next_state == ACCUM);
            if (w_last) begin
                r_acc           <= '0;
                r_cnt           <= '0;
                r_pending_pitch <= w_sum[ACC_W-1:AVG_LOG2];
            end else if (w_hs) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending_filter <= FILT_NONE;
            r_filter         <= FILT_NONE;
            r_pitch          <= '0;
            r_update         <= 1'b0;
        end else begin
            if (w_rise) begin
                r_pending_filter <= next_filter(r_pending_filter, NUM_FILTERS);
            end
            if (frame_start) begin
                r_filter <= r_pending_filter;
            end
            if (w_commit_pitch) begin
                r_pitch <= r_pending_pitch;
            end
            r_update <= frame_start &&
                        ((r_pending_filter != r_filter) ||
                         (w_commit_pitch && (r_pending_pitch != r_pitch)));
        end
    end

    assign pitch_ready   = r_ready;
    assign filter_number = r_filter;
    assign audio_pitch   = r_pitch;
    assign update        = r_update;

endmodule
`default_nettype wire
